// File: rtl/sha256_pkg.sv
// Shared SHA-256 schedule helpers: small sigma functions, padding constants and FSM state codes.
package sha256_pkg;

    localparam logic [31:0] SHA_PAD_WORD    = 32'h80000000;
    localparam logic [31:0] SHA_LEN256_WORD = 32'h00000100;

    localparam logic [0:0] ST_LOAD   = 1'b0;
    localparam logic [0:0] ST_EXPAND = 1'b1;

    // s0 = ROTR7 ^ ROTR18 ^ SHR3
    function automatic logic [31:0] sha256_s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    // s1 = ROTR17 ^ ROTR19 ^ SHR10
    function automatic logic [31:0] sha256_s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

endpackage

// File: rtl/sha256_sched_window.sv
// 16-word sliding window of the message schedule; win[0] is the oldest word, new words enter at win[15].
module sha256_sched_window (
    input  logic        clk,
    input  logic        shift_en,
    input  logic [31:0] din,
    output logic [31:0] tap0,
    output logic [31:0] tap1,
    output logic [31:0] tap9,
    output logic [31:0] tap14
);

    logic [31:0] win [16];

    // NOTE: pure datapath storage carries no reset; every block overwrites it from word 0 before use.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            for (int i = 0; i < 15; i++) begin
                win[i] <= win[i+1];
            end
            win[15] <= din;
        end
    end

    assign tap0  = win[0];
    assign tap1  = win[1];
    assign tap9  = win[9];
    assign tap14 = win[14];

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: passes W[0..15] through, then expands W[16..ROUNDS-1] from the window.
// Optional feature: define SCHED_PAD_EN to synthesise the padding of a single 256-bit-digest block.
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64,
    parameter int IDX_W  = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             pad_mode,
    output logic             w_valid,
    input  logic             w_ready,
    output logic [31:0]      w_data,
    output logic [IDX_W-1:0] w_idx,
    output logic             blk_done,
    output logic             busy
);

    localparam logic [IDX_W-1:0] T_LAST      = IDX_W'(ROUNDS - 1);
    localparam logic [IDX_W-1:0] T_LOAD_LAST = IDX_W'(15);
    localparam logic [IDX_W-1:0] T_PAD_FIRST = IDX_W'(8);
    localparam logic [IDX_W-1:0] T_ONE       = IDX_W'(1);

    logic [0:0]       state;
    logic [IDX_W-1:0] t;
    logic             live;
    logic             busy_q;
    logic             hs;
    logic             word0_hs;
    logic             pad_now;
    logic [31:0]      pad_word;
    logic [31:0]      expand_word;
    logic [31:0]      tap0, tap1, tap9, tap14;

    sha256_sched_window u_window (
        .clk      (clk),
        .shift_en (hs),
        .din      (w_data),
        .tap0     (tap0),
        .tap1     (tap1),
        .tap9     (tap9),
        .tap14    (tap14)
    );

    assign expand_word = sha256_s1(tap14) + tap9 + sha256_s0(tap1) + tap0;
    assign pad_word    = (t == T_PAD_FIRST) ? SHA_PAD_WORD :
                         (t == T_LOAD_LAST) ? SHA_LEN256_WORD : 32'h0;

`ifdef SCHED_PAD_EN
    logic pad_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pad_q <= 1'b0;
        end else if (word0_hs) begin
            pad_q <= pad_mode;
        end
    end

    assign pad_now = pad_q && (state == ST_LOAD) && (t >= T_PAD_FIRST);
`else
    logic unused_pad_mode;
    assign unused_pad_mode = pad_mode;
    assign pad_now         = 1'b0;
`endif

    // Outputs stay quiet during reset and for the first cycle after it (live is still low).
    // NOTE: every output of this combinational block gets a default first, so no latch can form.
    always_comb begin
        w_valid  = 1'b0;
        in_ready = 1'b0;
        w_data   = expand_word;
        if (state == ST_EXPAND) begin
            w_valid = live & rst_n;
        end else if (pad_now) begin
            w_valid = live & rst_n;
            w_data  = pad_word;
        end else begin
            w_valid  = live & rst_n & in_valid;
            in_ready = live & rst_n & w_ready;
            w_data   = in_data;
        end
    end

    assign hs       = w_valid & w_ready;
    assign word0_hs = hs && (state == ST_LOAD) && (t == '0);
    assign w_idx    = t;
    assign busy     = busy_q | word0_hs;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_LOAD;
            t        <= '0;
            live     <= 1'b0;
            blk_done <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            live     <= 1'b1;
            blk_done <= hs && (t == T_LAST);
            if (hs) begin
                if (t == T_LAST) begin
                    t      <= '0;
                    state  <= ST_LOAD;
                    busy_q <= 1'b0;
                end else begin
                    t      <= t + T_ONE;
                    busy_q <= 1'b1;
                    if (t == T_LOAD_LAST) begin
                        state <= ST_EXPAND;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: "abc" and zero blocks, stalls, mid-block reset, back-to-back blocks.
module tb_sha256_msg_schedule;

    localparam int ROUNDS = 64;
    localparam int IDX_W  = 7;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             pad_mode;
    logic             w_valid;
    logic             w_ready;
    logic [31:0]      w_data;
    logic [IDX_W-1:0] w_idx;
    logic             blk_done;
    logic             busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] src   [16];
    logic [31:0] exp_w [64];
    logic [31:0] cap   [64];
    bit          word0_on_done;

    always #5 clk = ~clk;

    sha256_msg_schedule #(.ROUNDS(ROUNDS), .IDX_W(IDX_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .pad_mode (pad_mode),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_data   (w_data),
        .w_idx    (w_idx),
        .blk_done (blk_done),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x};
        return d[n +: 32];
    endfunction

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic build_expected();
        for (int i = 0; i < 16; i++) exp_w[i] = src[i];
        for (int i = 16; i < 64; i++)
            exp_w[i] = ref_s1(exp_w[i-2]) + exp_w[i-7] + ref_s0(exp_w[i-15]) + exp_w[i-16];
    endtask

    task automatic load_abc();
        for (int i = 0; i < 16; i++) src[i] = 32'h0;
        src[0]  = 32'h61626380;
        src[15] = 32'h00000018;
        build_expected();
    endtask

    // Producer and consumer in one loop; abort_idx >= 0 pulses reset when W[abort_idx] is next.
    task automatic run_stream(input int n_blocks, input bit toggle, input int abort_idx,
                              input bit pad, input int n_words);
        int          prod_blk, prod_word, cons;
        bit          last_final, stalled, hs, in_hs;
        logic [31:0] held_d;
        logic [31:0] held_i;
        prod_blk = 0; prod_word = 0; cons = 0;
        last_final = 0; stalled = 0; word0_on_done = 0;
        held_d = '0; held_i = '0;
        for (int cyc = 0; cyc < 2000 && cons < n_blocks * ROUNDS; cyc++) begin
            @(negedge clk);
            if (abort_idx >= 0 && cons == abort_idx) begin
                rst_n = 1'b0; in_valid = 1'b0; w_ready = 1'b1; pad_mode = 1'b0;
                #1;
                check("valid_in_reset", w_valid, 0);
                @(negedge clk);
                rst_n = 1'b1; in_valid = 1'b1; in_data = src[0];
                #1;
                check("valid_after_reset", w_valid, 0);
                check("ready_after_reset", in_ready, 0);
                check("busy_after_reset", busy, 0);
                check("done_after_reset", blk_done, 0);
                in_valid = 1'b0;
                return;
            end
            w_ready  = toggle ? ((cyc % 2) == 0) : 1'b1;
            in_valid = (prod_blk < n_blocks) && (prod_word < n_words);
            in_data  = src[prod_word];
            pad_mode = pad && (prod_word == 0);
            #1;
            hs    = w_valid & w_ready;
            in_hs = in_valid & in_ready;
            check("blk_done", blk_done, last_final);
            if (last_final) begin
                check("busy_at_done", busy, in_hs && prod_word == 0);
                if (in_hs && prod_word == 0) word0_on_done = 1;
            end
            if (stalled) begin
                check("held_data", w_data, held_d);
                check("held_idx", w_idx, held_i);
            end
            if (!w_ready) check("in_ready_stall", in_ready, 0);
            if (hs) begin
                check("w_idx", w_idx, cons % ROUNDS);
                check("w_data", w_data, exp_w[cons % ROUNDS]);
                check("busy", busy, 1);
                if (pad && (cons % ROUNDS) >= 8 && (cons % ROUNDS) <= 15)
                    check("pad_in_ready", in_ready, 0);
                cap[cons % ROUNDS] = w_data;
            end
            last_final = hs && ((cons % ROUNDS) == ROUNDS - 1);
            if (hs) cons++;
            stalled = w_valid & !w_ready;
            held_d  = w_data;
            held_i  = 32'(w_idx);
            if (in_hs) begin
                prod_word++;
                if (prod_word == n_words) begin
                    prod_word = 0;
                    prod_blk++;
                end
            end
        end
        check("beats_done", cons, n_blocks * ROUNDS);
        @(negedge clk);
        in_valid = 1'b0;
        pad_mode = 1'b0;
        #1;
        check("blk_done_final", blk_done, 1);
        check("busy_end", busy, 0);
        check("valid_end", w_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; pad_mode = 1'b0; w_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", w_valid, 0);
        check("rst_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", blk_done, 0);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b1; w_ready = 1'b1;
        #1;
        check("post_rst_valid", w_valid, 0);
        check("post_rst_ready", in_ready, 0);
        check("post_rst_idx", w_idx, 0);
        in_valid = 1'b0;

        // 1: "abc" block, free-running consumer
        load_abc();
        run_stream(1, 1'b0, -1, 1'b0, 16);
        check("abc_w16", cap[16], 32'h61626380);
        check("abc_w17", cap[17], 32'h000F0000);
        check("abc_w18", cap[18], 32'h7DA86405);

        // 2: all-zero block
        for (int i = 0; i < 16; i++) src[i] = 32'h0;
        build_expected();
        run_stream(1, 1'b0, -1, 1'b0, 16);
        check("zero_w63", cap[63], 32'h0);

        // 3: "abc" with w_ready toggling every cycle
        load_abc();
        run_stream(1, 1'b1, -1, 1'b0, 16);
        check("toggle_w18", cap[18], 32'h7DA86405);

        // 4: reset at t=30, then a fresh block
        run_stream(1, 1'b0, 30, 1'b0, 16);
        run_stream(1, 1'b0, -1, 1'b0, 16);
        check("fresh_w17", cap[17], 32'h000F0000);

        // 5: two blocks back-to-back
        run_stream(2, 1'b0, -1, 1'b0, 16);
        check("b2b_word0_on_done", word0_on_done, 1);

`ifdef SCHED_PAD_EN
        // 6: padded block from 8 zero words
        for (int i = 0; i < 16; i++) src[i] = 32'h0;
        src[8]  = 32'h80000000;
        src[15] = 32'h00000100;
        build_expected();
        run_stream(1, 1'b0, -1, 1'b1, 8);
        check("pad_w8", cap[8], 32'h80000000);
        check("pad_w15", cap[15], 32'h00000100);
        check("pad_w16", cap[16], 32'h0);
        check("pad_w17", cap[17], 32'h00A00000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
